// File: rtl/wb_register_file_if.sv
// -----------------------------------------------------------------------------
// wb_register_file_if
// Bundles the register-file traffic between the pipeline (ID/WB side, master)
// and the architectural register file (slave).
//   src1, src2    : read port register indices (15 = PC, reads as zero)
//   two_src       : src2 is a real operand and takes part in the hazard check
//   issue_en/dest : a write-producing instruction leaves ID into EX
//   wb_en/dest/val: write-back triple from the WB stage
//   rd1, rd2      : combinational read data with same-cycle write-back bypass
//   hazard        : an operand still has a write in flight
//   sb_err        : sticky scoreboard over/underflow flag
// -----------------------------------------------------------------------------
interface wb_register_file_if #(
  parameter int N = 32
) ();
  logic [3:0]   src1;
  logic [3:0]   src2;
  logic         two_src;
  logic         issue_en;
  logic [3:0]   issue_dest;
  logic         wb_en;
  logic [3:0]   wb_dest;
  logic [N-1:0] wb_value;
  logic [N-1:0] rd1;
  logic [N-1:0] rd2;
  logic         hazard;
  logic         sb_err;

  modport master (
    output src1, src2, two_src, issue_en, issue_dest, wb_en, wb_dest, wb_value,
    input  rd1, rd2, hazard, sb_err
  );

  modport slave (
    input  src1, src2, two_src, issue_en, issue_dest, wb_en, wb_dest, wb_value,
    output rd1, rd2, hazard, sb_err
  );
endinterface

// File: rtl/wb_register_file.sv
// -----------------------------------------------------------------------------
// wb_register_file
// Architectural register file R0..R14 plus a per-register pending-write
// scoreboard. Index 15 is the PC and is never stored.
//   clk : rising-edge clock for all state
//   rst : asynchronous, active-high reset
//   bus : wb_register_file_if.slave (read ports, issue and write-back inputs,
//         read data, hazard and sticky scoreboard error outputs)
// -----------------------------------------------------------------------------
module wb_register_file #(
  parameter int N     = 32,
  parameter int CNT_W = 2
) (
  input logic              clk,
  input logic              rst,
  wb_register_file_if.slave bus
);

  localparam int         NREGS  = 15;
  localparam logic [3:0] PC_IDX = 4'd15;

  logic [N-1:0]     regFile_q [NREGS];
  logic [CNT_W-1:0] pend_q    [NREGS];
  logic [CNT_W-1:0] pend_d    [NREGS];
  logic             sbErr_q;
  logic             sbErr_d;

  logic [NREGS-1:0] incVec;
  logic [NREGS-1:0] decVec;

  logic [N-1:0]     rawRd1;
  logic [N-1:0]     rawRd2;
  logic [CNT_W-1:0] pendSrc1;
  logic [CNT_W-1:0] pendSrc2;
  logic [CNT_W-1:0] leftSrc1;
  logic [CNT_W-1:0] leftSrc2;
  logic             dec1;
  logic             dec2;
  logic             busy1;
  logic             busy2;

  // One-hot decode of the issuing and retiring destinations. Index 15 never
  // matches any entry, so PC writes and PC issues fall out as no-ops.
  always_comb begin
    incVec = '0;
    decVec = '0;
    for (int r = 0; r < NREGS; r++) begin
      incVec[r] = bus.issue_en && (bus.issue_dest == 4'(r));
      decVec[r] = bus.wb_en    && (bus.wb_dest    == 4'(r));
    end
  end

  // Register storage: a retiring write lands in its destination on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regFile_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (decVec[r]) regFile_q[r] <= bus.wb_value;
      end
    end
  end

  // Scoreboard next state. Issue and retire on the same register cancel.
  // Counting past the maximum or below zero holds the counter and raises the
  // sticky error instead of wrapping, since the pipeline depth should make
  // either case impossible.
  always_comb begin
    sbErr_d = sbErr_q;
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r] = pend_q[r];
      if (incVec[r] && !decVec[r]) begin
        if (pend_q[r] == '1) sbErr_d = 1'b1;
        else                 pend_d[r] = pend_q[r] + CNT_W'(1);
      end else if (decVec[r] && !incVec[r]) begin
        if (pend_q[r] == '0) sbErr_d = 1'b1;
        else                 pend_d[r] = pend_q[r] - CNT_W'(1);
      end
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
      sbErr_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
      sbErr_q <= sbErr_d;
    end
  end

  // Select the stored value and pending count behind each read index.
  always_comb begin
    rawRd1   = '0;
    rawRd2   = '0;
    pendSrc1 = '0;
    pendSrc2 = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (bus.src1 == 4'(r)) begin
        rawRd1   = regFile_q[r];
        pendSrc1 = pend_q[r];
      end
      if (bus.src2 == 4'(r)) begin
        rawRd2   = regFile_q[r];
        pendSrc2 = pend_q[r];
      end
    end
  end

  // A write retiring this cycle is forwarded straight to the reader, so it no
  // longer counts as outstanding for the hazard check.
  assign dec1     = bus.wb_en && (bus.wb_dest == bus.src1);
  assign dec2     = bus.wb_en && (bus.wb_dest == bus.src2);
  assign leftSrc1 = pendSrc1 - CNT_W'(dec1);
  assign leftSrc2 = pendSrc2 - CNT_W'(dec2);
  assign busy1    = (bus.src1 != PC_IDX) && (leftSrc1 != '0);
  assign busy2    = (bus.src2 != PC_IDX) && (leftSrc2 != '0);

  assign bus.rd1    = (bus.src1 == PC_IDX) ? '0 : (dec1 ? bus.wb_value : rawRd1);
  assign bus.rd2    = (bus.src2 == PC_IDX) ? '0 : (dec2 ? bus.wb_value : rawRd2);
  assign bus.hazard = !rst && (busy1 || (bus.two_src && busy2));
  assign bus.sb_err = sbErr_q;

endmodule

// File: tb/tb_wb_register_file.sv
// -----------------------------------------------------------------------------
// tb_wb_register_file
// Self-checking bench for wb_register_file. A behavioural model (plain arrays
// of register values and in-flight counts) predicts every output; directed
// scenarios are followed by a randomized stream with occasional async resets.
// -----------------------------------------------------------------------------
module tb_wb_register_file;

  logic clk;
  logic rst;

  wb_register_file_if #(.N(32)) bus ();

  wb_register_file #(.N(32), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] mRegs [15];
  int          mPend [15];
  bit          mErr;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Model: the architectural value seen by a reader this cycle.
  function automatic logic [31:0] expRead(input logic [3:0] s);
    if (s == 4'd15) return 32'h0;
    if (bus.wb_en && bus.wb_dest == s) return bus.wb_value;
    return mRegs[s];
  endfunction

  // Model: outstanding writes after counting this cycle's retirement, mod 4.
  function automatic bit expBusy(input logic [3:0] s);
    int d;
    if (s == 4'd15) return 1'b0;
    d = (bus.wb_en && bus.wb_dest == s) ? 1 : 0;
    return ((mPend[s] - d + 4) % 4) != 0;
  endfunction

  function automatic bit expHazard();
    if (rst) return 1'b0;
    return expBusy(bus.src1) || (bus.two_src && expBusy(bus.src2));
  endfunction

  // Model: one clock edge worth of scoreboard and register updates.
  task automatic modelUpdate();
    for (int r = 0; r < 15; r++) begin
      bit inc;
      bit dec;
      inc = bus.issue_en && bus.issue_dest == 4'(r);
      dec = bus.wb_en && bus.wb_dest == 4'(r);
      if (inc && !dec) begin
        if (mPend[r] == 3) mErr = 1'b1;
        else               mPend[r]++;
      end else if (dec && !inc) begin
        if (mPend[r] == 0) mErr = 1'b1;
        else               mPend[r]--;
      end
    end
    if (bus.wb_en && bus.wb_dest != 4'd15) mRegs[bus.wb_dest] = bus.wb_value;
  endtask

  task automatic modelReset();
    for (int r = 0; r < 15; r++) begin
      mRegs[r] = 32'h0;
      mPend[r] = 0;
    end
    mErr = 1'b0;
  endtask

  // Compare every output against the model.
  task automatic checkModel(input string tag);
    checkOutput({tag, "/rd1"},    bus.rd1,          expRead(bus.src1));
    checkOutput({tag, "/rd2"},    bus.rd2,          expRead(bus.src2));
    checkOutput({tag, "/hazard"}, 32'(bus.hazard),  32'(expHazard()));
    checkOutput({tag, "/sb_err"}, 32'(bus.sb_err),  32'(mErr));
  endtask

  // Drive one cycle of inputs and let the combinational paths settle.
  task automatic applyStimulus(input logic [3:0] s1, input logic [3:0] s2,
                               input logic two, input logic iss,
                               input logic [3:0] issDest, input logic wb,
                               input logic [3:0] wbDest, input logic [31:0] wbVal);
    bus.src1       = s1;
    bus.src2       = s2;
    bus.two_src    = two;
    bus.issue_en   = iss;
    bus.issue_dest = issDest;
    bus.wb_en      = wb;
    bus.wb_dest    = wbDest;
    bus.wb_value   = wbVal;
    #1;
  endtask

  // Advance through the next rising edge, updating the model alongside.
  task automatic tick();
    @(posedge clk);
    if (!rst) modelUpdate();
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle, released after the next edge.
  task automatic pulseReset(input string tag);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkModel(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    modelReset();
    applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    #1;
    checkModel("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Bypass: set R5 = 0x11 legitimately, then forward 0x22 in the same cycle.
    applyStimulus(4'd5, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 32'h0);
    tick();
    applyStimulus(4'd5, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 32'h11);
    tick();
    applyStimulus(4'd5, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 32'h0);
    checkOutput("bypass_old", bus.rd1, 32'h11);
    tick();
    applyStimulus(4'd5, 4'd5, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5, 32'h22);
    checkOutput("bypass_same", bus.rd1, 32'h22);
    checkOutput("bypass_haz", 32'(bus.hazard), 32'h0);
    checkModel("bypass");
    tick();
    applyStimulus(4'd5, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    checkOutput("bypass_after", bus.rd1, 32'h22);
    checkOutput("bypass_err", 32'(bus.sb_err), 32'h0);

    // RAW lifecycle on R2.
    applyStimulus(4'd2, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 32'h0);
    checkOutput("raw_k", 32'(bus.hazard), 32'h0);
    tick();
    applyStimulus(4'd2, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    checkOutput("raw_k1", 32'(bus.hazard), 32'h1);
    tick();
    checkOutput("raw_k2", 32'(bus.hazard), 32'h1);
    tick();
    applyStimulus(4'd2, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd2, 32'hA5A5_0002);
    checkOutput("raw_k3_haz", 32'(bus.hazard), 32'h0);
    checkOutput("raw_k3_rd", bus.rd1, 32'hA5A5_0002);
    tick();
    applyStimulus(4'd2, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    checkOutput("raw_after", 32'(bus.hazard), 32'h0);
    checkModel("raw");

    // two_src gating with one write pending on R7.
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 32'h0);
    tick();
    applyStimulus(4'd0, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    checkOutput("two_src0", 32'(bus.hazard), 32'h0);
    applyStimulus(4'd0, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    checkOutput("two_src1", 32'(bus.hazard), 32'h1);
    applyStimulus(4'd0, 4'd7, 1'b1, 1'b0, 4'd0, 1'b1, 4'd7, 32'h77);
    tick();

    // Simultaneous issue and retire on R4 with one already pending.
    applyStimulus(4'd4, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 32'h0);
    tick();
    applyStimulus(4'd4, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1, 4'd4, 32'h44);
    checkModel("simul");
    tick();
    applyStimulus(4'd4, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    checkOutput("simul_haz", 32'(bus.hazard), 32'h1);
    checkOutput("simul_err", 32'(bus.sb_err), 32'h0);
    checkOutput("simul_rd", bus.rd1, 32'h44);
    applyStimulus(4'd4, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd4, 32'h45);
    tick();

    // PC index 15: writes and issues are ignored, reads are zero.
    applyStimulus(4'd15, 4'd15, 1'b1, 1'b1, 4'd15, 1'b1, 4'd15, 32'hFFFF_FFFF);
    checkOutput("pc_rd1", bus.rd1, 32'h0);
    checkOutput("pc_haz", 32'(bus.hazard), 32'h0);
    tick();
    applyStimulus(4'd15, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    checkOutput("pc_rd1_after", bus.rd1, 32'h0);
    checkOutput("pc_r4_kept", bus.rd2, 32'h45);
    checkOutput("pc_err", 32'(bus.sb_err), 32'h0);
    checkModel("pc");

    // Mid-cycle reset with R3 holding data and a write still in flight.
    applyStimulus(4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 32'h0);
    tick();
    applyStimulus(4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 4'd3, 32'hDEAD_BEEF);
    tick();
    applyStimulus(4'd3, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    checkOutput("pre_rst_rd", bus.rd1, 32'hDEAD_BEEF);
    checkOutput("pre_rst_haz", 32'(bus.hazard), 32'h1);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_rd1", bus.rd1, 32'h0);
    checkOutput("rst_haz", 32'(bus.hazard), 32'h0);
    checkOutput("rst_err", 32'(bus.sb_err), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Overflow: four issues to R9 saturate at three and flag the error.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'd9, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0, 4'd0, 32'h0);
      tick();
    end
    applyStimulus(4'd9, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    checkOutput("ovf_err", 32'(bus.sb_err), 32'h1);
    checkOutput("ovf_haz", 32'(bus.hazard), 32'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'd9, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 32'(i + 9));
      tick();
    end
    applyStimulus(4'd9, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    checkOutput("ovf_drained", 32'(bus.hazard), 32'h0);
    checkOutput("ovf_sticky", 32'(bus.sb_err), 32'h1);
    pulseReset("ovf_rst");

    // Underflow: retire to R1 with nothing pending still writes R1.
    applyStimulus(4'd1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 32'h0000_0055);
    tick();
    applyStimulus(4'd1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    checkOutput("unf_err", 32'(bus.sb_err), 32'h1);
    checkOutput("unf_rd", bus.rd1, 32'h0000_0055);
    pulseReset("unf_rst");

    // Randomized traffic, mostly legal, with occasional async resets.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] wbDest;
      logic [3:0] issDest;
      logic       iss;
      int         start;
      wbDest = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 8) begin
        start = $urandom_range(0, 14);
        for (int k = 0; k < 15; k++) begin
          if (mPend[(start + k) % 15] > 0) begin
            wbDest = 4'((start + k) % 15);
            break;
          end
        end
      end
      issDest = 4'($urandom_range(0, 15));
      iss     = 1'($urandom_range(0, 1));
      if (iss && issDest != 4'd15 && mPend[issDest] == 3 && $urandom_range(0, 9) != 0)
        iss = 1'b0;
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), iss, issDest,
                    1'($urandom_range(0, 1)), wbDest, $urandom);
      checkModel($sformatf("rand%0d", n));
      if (n % 97 == 96) pulseReset($sformatf("rand_rst%0d", n));
      else              tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
